// File: rtl/quad_speed_meter_pkg.sv
// Shared types and constants for the quadrature speed meter.
// Optional glitch filter is selected with the QUAD_GLITCH_FILTER_EN macro.
package quad_enc_pkg;

   localparam int SPEED_W = 32;
   localparam int POS_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   localparam logic [POS_W-1:0] STEP_CW  = 32'h0000_0001;
   localparam logic [POS_W-1:0] STEP_CCW = 32'hFFFF_FFFF;

   // B low at an A rise means clockwise rotation.
   function automatic logic [POS_W-1:0] pos_step(input logic b_level);
      return b_level ? STEP_CCW : STEP_CW;
   endfunction

endpackage

// File: rtl/quad_speed_meter_if.sv
// Encoder pins and measurement results of the quadrature speed meter.
// The master modport is the meter itself; slave is the encoder/consumer side.
interface quad_speed_meter_if;
   import quad_enc_pkg::*;

   logic               enc_a_raw;
   logic               enc_b_raw;
   logic               enc_a_q;
   logic               enc_b_q;
   logic [SPEED_W-1:0] wheel_speed;
   logic               speed_valid;
   logic [POS_W-1:0]   position;

   modport master (
      input  enc_a_raw,
      input  enc_b_raw,
      output enc_a_q,
      output enc_b_q,
      output wheel_speed,
      output speed_valid,
      output position
   );

   modport slave (
      output enc_a_raw,
      output enc_b_raw,
      input  enc_a_q,
      input  enc_b_q,
      input  wheel_speed,
      input  speed_valid,
      input  position
   );

endinterface

// File: rtl/quad_speed_meter_input_conditioner.sv
// One encoder channel: synchroniser chain, plus a stable-sample glitch filter
// when QUAD_GLITCH_FILTER_EN is defined.
module quad_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic raw_in,
   output logic level_out
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_out_s;

   // Shift the raw pin into the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
   end

   // Synchroniser flops.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out_s = sync_q[SYNC_STAGES-1];

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Accept a new level only after FILTER_LEN consecutive differing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_out_s == level_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
         level_d = sync_out_s;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Filter state flops.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         level_q <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_out = level_q;
`else
   assign level_out = sync_out_s;
`endif

endmodule

// File: rtl/quad_speed_meter.sv
// Quadrature front end: A-rise period measurement, stop detection and signed
// position count. Build with QUAD_GLITCH_FILTER_EN to enable the input filter.
module quad_speed_meter
   import quad_enc_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int FILTER_LEN     = 4
) (
   input  logic                CLK,
   input  logic                RST_n,
   quad_speed_meter_if.master  bus
);

   localparam logic [SPEED_W-1:0] TIMEOUT_VAL = SPEED_W'(TIMEOUT_CYCLES);

   logic               a_lvl_s;
   logic               b_lvl_s;
   logic               a_rise_s;
   logic               timeout_s;

   logic               a_dly_q,       a_dly_d;
   logic [SPEED_W-1:0] count_q,       count_d;
   state_e             state_q,       state_d;
   logic [SPEED_W-1:0] wheel_speed_q, wheel_speed_d;
   logic               speed_valid_q, speed_valid_d;
   logic [POS_W-1:0]   position_q,    position_d;

   quad_input_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_cond_a (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .raw_in    (bus.enc_a_raw),
      .level_out (a_lvl_s)
   );

   quad_input_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_cond_b (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .raw_in    (bus.enc_b_raw),
      .level_out (b_lvl_s)
   );

   assign a_rise_s  = a_lvl_s & ~a_dly_q;
   assign timeout_s = (count_q == TIMEOUT_VAL);

   // Edge history, period counter, FSM next state and position update.
   always_comb begin
      a_dly_d       = a_lvl_s;
      state_d       = state_q;
      wheel_speed_d = wheel_speed_q;
      speed_valid_d = 1'b0;
      position_d    = position_q;

      if (a_rise_s) begin
         count_d = {{(SPEED_W-1){1'b0}}, 1'b1};
      end else if (timeout_s) begin
         count_d = count_q;
      end else begin
         count_d = count_q + {{(SPEED_W-1){1'b0}}, 1'b1};
      end

      if (a_rise_s) begin
         position_d = position_q + pos_step(b_lvl_s);
      end else begin
         position_d = position_q;
      end

      // An A rise takes priority over a coincident timeout.
      case (state_q)
         ST_IDLE: begin
            wheel_speed_d = {SPEED_W{1'b0}};
            if (a_rise_s) begin
               state_d = ST_ARMED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (a_rise_s) begin
               state_d       = ST_RUN;
               wheel_speed_d = count_q;
               speed_valid_d = 1'b1;
            end else if (timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_RUN: begin
            if (a_rise_s) begin
               wheel_speed_d = count_q;
               speed_valid_d = 1'b1;
            end else if (timeout_s) begin
               state_d       = ST_IDLE;
               wheel_speed_d = {SPEED_W{1'b0}};
               speed_valid_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            wheel_speed_d = {SPEED_W{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         a_dly_q       <= 1'b0;
         count_q       <= {SPEED_W{1'b0}};
         state_q       <= ST_IDLE;
         wheel_speed_q <= {SPEED_W{1'b0}};
         speed_valid_q <= 1'b0;
         position_q    <= {POS_W{1'b0}};
      end else begin
         a_dly_q       <= a_dly_d;
         count_q       <= count_d;
         state_q       <= state_d;
         wheel_speed_q <= wheel_speed_d;
         speed_valid_q <= speed_valid_d;
         position_q    <= position_d;
      end
   end

   assign bus.enc_a_q     = a_lvl_s;
   assign bus.enc_b_q     = b_lvl_s;
   assign bus.wheel_speed = wheel_speed_q;
   assign bus.speed_valid = speed_valid_q;
   assign bus.position    = position_q;

endmodule

// File: tb/tb_quad_speed_meter.sv
// Directed bench for quad_speed_meter; expected glitch results follow
// QUAD_GLITCH_FILTER_EN.
module tb_quad_speed_meter;
   import quad_enc_pkg::*;

   localparam int TIMEOUT = 1000;

`ifdef QUAD_GLITCH_FILTER_EN
   localparam logic [31:0] EXP_GLITCH_POS = 32'd0;
   localparam logic [31:0] EXP_PULSE_POS  = 32'd1;
`else
   localparam logic [31:0] EXP_GLITCH_POS = 32'd1;
   localparam logic [31:0] EXP_PULSE_POS  = 32'd2;
`endif

   logic CLK = 1'b0;
   logic RST_n;
   always #5 CLK = ~CLK;

   quad_speed_meter_if bus ();

   quad_speed_meter #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FILTER_LEN     (4)
   ) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .bus   (bus.master)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int sv_cnt = 0;
   int sv_100 = 0;
   int last_sv_cyc = 0;
   int prev_sv_cyc = 0;
   logic [31:0] last_speed = 32'd0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Strobe monitor: counts speed_valid pulses and their values/times.
   always @(negedge CLK) begin
      if (bus.speed_valid === 1'b1) begin
         sv_cnt      <= sv_cnt + 1;
         if (bus.wheel_speed === 32'd100) sv_100 <= sv_100 + 1;
         last_speed  <= bus.wheel_speed;
         prev_sv_cyc <= last_sv_cyc;
         last_sv_cyc <= cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic apply_reset();
      bus.enc_a_raw = 1'b0;
      bus.enc_b_raw = 1'b0;
      RST_n = 1'b0;
      step(3);
      RST_n = 1'b1;
      step(2);
   endtask

   task automatic a_period(input int hi, input int lo);
      bus.enc_a_raw = 1'b1;
      step(hi);
      bus.enc_a_raw = 1'b0;
      step(lo);
   endtask

   task automatic test_reset();
      int base;
      bus.enc_a_raw = 1'b0;
      bus.enc_b_raw = 1'b0;
      RST_n = 1'b0;
      step(1);
      n_cmp++;
      if (bus.wheel_speed !== 32'd0 || bus.position !== 32'd0 || bus.speed_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got speed=%h pos=%h valid=%b expected all 0",
                  bus.wheel_speed, bus.position, bus.speed_valid);
      end
      n_cmp++;
      if (dut.state_q !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
      end
      RST_n = 1'b1;
      step(2);
      repeat (3) a_period(50, 50);
      n_cmp++;
      if (dut.state_q !== ST_RUN) begin
         n_fail++;
         $display("FAIL pre_reset_run: got %0d expected %0d", dut.state_q, ST_RUN);
      end
      bus.enc_a_raw = 1'b1;
      step(4);
      #2 RST_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.wheel_speed !== 32'd0 || bus.position !== 32'd0 || bus.speed_valid !== 1'b0 ||
          bus.enc_a_q !== 1'b0 || bus.enc_b_q !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: got speed=%h pos=%h valid=%b a=%b b=%b expected all 0",
                  bus.wheel_speed, bus.position, bus.speed_valid, bus.enc_a_q, bus.enc_b_q);
      end
      n_cmp++;
      if (dut.state_q !== ST_IDLE) begin
         n_fail++;
         $display("FAIL midrun_reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
      end
      bus.enc_a_raw = 1'b0;
      step(2);
      RST_n = 1'b1;
      step(2);
      base = sv_cnt;
      a_period(50, 50);
      n_cmp++;
      if (sv_cnt !== base) begin
         n_fail++;
         $display("FAIL first_edge_no_valid: got %0d strobes expected 0", sv_cnt - base);
      end
      n_cmp++;
      if (dut.state_q !== ST_ARMED || bus.position !== 32'd1) begin
         n_fail++;
         $display("FAIL first_edge_armed: got state=%0d pos=%h expected state=%0d pos=%h",
                  dut.state_q, bus.position, ST_ARMED, 32'd1);
      end
   endtask

   task automatic test_direction(input logic b_lvl, input logic [31:0] exp_pos);
      int base;
      int base100;
      apply_reset();
      bus.enc_b_raw = b_lvl;
      step(10);
      base    = sv_cnt;
      base100 = sv_100;
      repeat (5) a_period(50, 50);
      n_cmp++;
      if (sv_cnt - base !== 4) begin
         n_fail++;
         $display("FAIL dir%0b_strobes: got %0d expected 4", b_lvl, sv_cnt - base);
      end
      n_cmp++;
      if (sv_100 - base100 !== 4) begin
         n_fail++;
         $display("FAIL dir%0b_speed100: got %0d strobes at 100 expected 4 (last %0d)",
                  b_lvl, sv_100 - base100, last_speed);
      end
      n_cmp++;
      if (bus.wheel_speed !== 32'd100) begin
         n_fail++;
         $display("FAIL dir%0b_wheel_speed: got %0d expected 100", b_lvl, bus.wheel_speed);
      end
      n_cmp++;
      if (bus.position !== exp_pos) begin
         n_fail++;
         $display("FAIL dir%0b_position: got %h expected %h", b_lvl, bus.position, exp_pos);
      end
      n_cmp++;
      if (bus.enc_b_q !== b_lvl) begin
         n_fail++;
         $display("FAIL dir%0b_enc_b_q: got %b expected %b", b_lvl, bus.enc_b_q, b_lvl);
      end
   endtask

   task automatic test_timeout();
      int base;
      base = sv_cnt;
      for (int i = 0; i < 1200; i++) begin
         step(1);
         if (sv_cnt != base) break;
      end
      step(1);
      n_cmp++;
      if (sv_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL timeout_strobe: got %0d strobes expected 1", sv_cnt - base);
      end
      n_cmp++;
      if (last_speed !== 32'd0 || bus.wheel_speed !== 32'd0) begin
         n_fail++;
         $display("FAIL timeout_speed: got strobe=%0d out=%0d expected 0", last_speed, bus.wheel_speed);
      end
      n_cmp++;
      if (last_sv_cyc - prev_sv_cyc !== TIMEOUT) begin
         n_fail++;
         $display("FAIL timeout_delay: got %0d cycles expected %0d", last_sv_cyc - prev_sv_cyc, TIMEOUT);
      end
      n_cmp++;
      if (dut.state_q !== ST_IDLE || bus.speed_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: got state=%0d valid=%b expected state=%0d valid=0",
                  dut.state_q, bus.speed_valid, ST_IDLE);
      end
      n_cmp++;
      if (bus.position !== 32'hFFFF_FFFB) begin
         n_fail++;
         $display("FAIL timeout_position: got %h expected %h", bus.position, 32'hFFFF_FFFB);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      bus.enc_a_raw = 1'b1;
      step(2);
      bus.enc_a_raw = 1'b0;
      step(20);
      n_cmp++;
      if (bus.position !== EXP_GLITCH_POS) begin
         n_fail++;
         $display("FAIL glitch_2cyc: got %h expected %h", bus.position, EXP_GLITCH_POS);
      end
      a_period(10, 20);
      n_cmp++;
      if (bus.position !== EXP_PULSE_POS) begin
         n_fail++;
         $display("FAIL pulse_10cyc: got %h expected %h", bus.position, EXP_PULSE_POS);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      force dut.position_q = 32'h7FFF_FFFF;
      step(1);
      release dut.position_q;
      step(1);
      n_cmp++;
      if (bus.position !== 32'h7FFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_preset: got %h expected %h", bus.position, 32'h7FFF_FFFF);
      end
      a_period(10, 20);
      n_cmp++;
      if (bus.position !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL wrap_cw: got %h expected %h", bus.position, 32'h8000_0000);
      end
      bus.enc_b_raw = 1'b1;
      step(10);
      a_period(10, 20);
      n_cmp++;
      if (bus.position !== 32'h7FFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_ccw: got %h expected %h", bus.position, 32'h7FFF_FFFF);
      end
   endtask

   initial begin
      test_reset();
      test_direction(1'b0, 32'd5);
      test_direction(1'b1, 32'hFFFF_FFFB);
      test_timeout();
      test_glitch();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
